// File: rtl/emap_row_sequencer.sv
// Row-level scheduler for the 8-wide gather unit: fetches one descriptor per
// row and walks the gather handshake once per chunk. Each chunk is handed to
// the multiply stage with valid/ready. Vector-memory writes are only let
// through while no pass is running.
module emap_row_sequencer #(
  parameter int NO_OF_UNITS = 8,
  parameter int ROW_WIDTH   = 16,
  parameter int NNZ_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ROW_WIDTH-1:0]  num_rows,
  input  logic [ADDR_WIDTH-1:0] desc_base,
  output logic                  desc_req,
  output logic [ADDR_WIDTH-1:0] desc_addr,
  input  logic                  desc_valid,
  input  logic [NNZ_WIDTH-1:0]  desc_nnz,
  output logic                  read_preprocess,
  output logic [31:0]           no_of_multiples,
  input  logic                  you_can_read,
  output logic                  I_am_ready,
  output logic                  chunk_valid,
  input  logic                  chunk_ready,
  output logic                  chunk_last,
  output logic                  row_last,
  output logic [NNZ_WIDTH-1:0]  chunk_idx,
  input  logic                  wr_req,
  output logic                  write_enable,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, WAIT_RD, SETTLE, PRESENT, ADVANCE, FIN
  } state_t;

  localparam logic [NNZ_WIDTH:0]   ROUND   = (NNZ_WIDTH+1)'(NO_OF_UNITS - 1);
  localparam logic [NNZ_WIDTH:0]   UNITS   = (NNZ_WIDTH+1)'(NO_OF_UNITS);
  localparam logic [NNZ_WIDTH-1:0] NNZ_ONE = NNZ_WIDTH'(1);
  localparam logic [ROW_WIDTH-1:0] ROW_ONE = ROW_WIDTH'(1);

  state_t                  state, state_nxt;
  logic                    start_pending;
  logic [ROW_WIDTH-1:0]    rows_q, row_idx;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [NNZ_WIDTH-1:0]    mult, chunk_idx_q, mult_nxt;
  logic [NNZ_WIDTH:0]      chunks_raw;
  logic                    busy_q;
  logic                    accept, more_chunks, more_rows;

  // Chunk count rounds up; carried one bit wider so nnz near max cannot wrap.
  // An empty row still needs one padded chunk.
  assign chunks_raw = ({1'b0, desc_nnz} + ROUND) / UNITS;
  assign mult_nxt   = (chunks_raw == '0) ? NNZ_ONE : chunks_raw[NNZ_WIDTH-1:0];

  // Writes win: a start (fresh or pending) is taken only on a write-free IDLE cycle.
  assign accept      = (state == IDLE) && (start || start_pending) && !wr_req;
  assign more_chunks = (chunk_idx_q != mult - NNZ_ONE);
  assign more_rows   = (row_idx != rows_q - ROW_ONE);

  assign desc_addr       = base_q + ADDR_WIDTH'(row_idx);
  assign no_of_multiples = 32'(mult);
  assign chunk_idx       = chunk_idx_q;
  assign busy            = busy_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (num_rows == '0) ? FIN : FETCH;
      FETCH:   if (desc_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT_RD;
      WAIT_RD: if (you_can_read) state_nxt = SETTLE;
      SETTLE:  state_nxt = PRESENT;
      PRESENT: if (chunk_ready) state_nxt = ADVANCE;
      ADVANCE: begin
        if (more_chunks)    state_nxt = WAIT_RD;
        else if (more_rows) state_nxt = FETCH;
        else                state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs, plus the IDLE-only write gate.
  always_comb begin
    desc_req        = (state == FETCH);
    read_preprocess = (state == ISSUE);
    I_am_ready      = (state == ADVANCE) && more_chunks;
    chunk_valid     = (state == PRESENT);
    chunk_last      = (state == PRESENT) && !more_chunks;
    row_last        = (state == PRESENT) && !more_rows;
    done            = (state == FIN);
    write_enable    = (state == IDLE) && wr_req;
  end

  // Pass bookkeeping: pending start, latched pass parameters, row/chunk counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_pending <= 1'b0;
      rows_q        <= '0;
      base_q        <= '0;
      row_idx       <= '0;
      mult          <= '0;
      chunk_idx_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (accept)     start_pending <= 1'b0;
        else if (start) start_pending <= 1'b1;
      end
      if (accept) begin
        rows_q  <= num_rows;
        base_q  <= desc_base;
        row_idx <= '0;
        busy_q  <= 1'b1;
      end
      if (state == FETCH && desc_valid) begin
        mult        <= mult_nxt;
        chunk_idx_q <= '0;
      end
      if (state == ADVANCE) begin
        if (more_chunks)    chunk_idx_q <= chunk_idx_q + NNZ_ONE;
        else if (more_rows) row_idx     <= row_idx + ROW_ONE;
      end
      if (state == FIN) busy_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_emap_row_sequencer.sv
// Bench for emap_row_sequencer: plays descriptor memory, gather unit and
// consumer with random timing, and checks every chunk against a per-row list
// built from the chunking rule max(1, ceil(nnz/8)).
module tb_emap_row_sequencer;
  localparam int U = 8;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] num_rows = '0;
  logic [31:0] desc_base = '0;
  logic        desc_req;
  logic [31:0] desc_addr;
  logic        desc_valid = 1'b0;
  logic [15:0] desc_nnz = '0;
  logic        read_preprocess;
  logic [31:0] no_of_multiples;
  logic        you_can_read = 1'b0;
  logic        I_am_ready, chunk_valid, chunk_last, row_last;
  logic        chunk_ready = 1'b0;
  logic [15:0] chunk_idx;
  logic        wr_req = 1'b0;
  logic        write_enable, busy, done;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct { int row; int idx; bit cl; bit rl; } chunk_t;
  chunk_t expq[$];
  int     nnz_tab[$];
  int     bnd[8] = '{0, 1, 7, 8, 9, 16, 17, 40};

  emap_row_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
    .desc_base(desc_base), .desc_req(desc_req), .desc_addr(desc_addr),
    .desc_valid(desc_valid), .desc_nnz(desc_nnz),
    .read_preprocess(read_preprocess), .no_of_multiples(no_of_multiples),
    .you_can_read(you_can_read), .I_am_ready(I_am_ready),
    .chunk_valid(chunk_valid), .chunk_ready(chunk_ready),
    .chunk_last(chunk_last), .row_last(row_last), .chunk_idx(chunk_idx),
    .wr_req(wr_req), .write_enable(write_enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int mult_of(input int n);
    return (n == 0) ? 1 : (n + U - 1) / U;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_flags"}, {23'd0, desc_req, read_preprocess, I_am_ready, chunk_valid,
         chunk_last, row_last, write_enable, busy, done}, 32'd0);
    chk({tag, "_nom"}, no_of_multiples, 32'd0);
    chk({tag, "_idx"}, 32'(chunk_idx), 32'd0);
    chk({tag, "_addr"}, desc_addr, 32'd0);
  endtask

  // One pass: responders act on what the DUT shows after each edge.
  task automatic run_pass(input int nrows, input logic [31:0] base, input int rmode,
                          input bit abort, input bit randwr, input bit pre);
    chunk_t e;
    int rp_n = 0, iar_n = 0, exp_iar = 0, stall = 0, gwait = -1;
    int dv_cyc = -100, ycr_cyc = -100;
    bit hold = 0, dseen = 0, finished = 0;
    logic [15:0] hidx = '0;
    logic hcl = 1'b0, hrl = 1'b0;
    expq.delete();
    for (int r = 0; r < nrows; r++) begin
      int m;
      m = mult_of(nnz_tab[r]);
      exp_iar += m - 1;
      for (int c = 0; c < m; c++) expq.push_back('{r, c, (c == m - 1), (r == nrows - 1)});
    end
    if (!pre) begin
      wr_req = 1'b0; num_rows = 16'(nrows); desc_base = base; start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int t = 0; t < 4000 && !finished; t++) begin
      chk("write_enable", 32'(write_enable), 32'(wr_req && !busy));
      // gather: real you_can_read after a delay; stray ones while idle must be ignored
      you_can_read = 1'b0;
      if (gwait > 0) begin
        gwait--;
        if (gwait == 0) begin you_can_read = 1'b1; ycr_cyc = cyc; gwait = -1; end
      end else if ($urandom_range(0, 3) == 0) you_can_read = 1'b1;
      // descriptor memory with random latency
      desc_valid = 1'b0;
      if (desc_req) begin
        if (!dseen) begin
          chk("desc_addr", desc_addr, base + 32'(rp_n));
          chk("desc_req_in_range", 32'(rp_n < nrows), 32'd1);
          dseen = 1;
        end
        if (rp_n < nrows && $urandom_range(0, 2) != 0) begin
          desc_valid = 1'b1; desc_nnz = 16'(nnz_tab[rp_n]); dv_cyc = cyc;
        end
      end
      if (read_preprocess) begin
        chk("rp_latency", 32'(cyc - dv_cyc), 32'd1);
        chk("rp_in_range", 32'(rp_n < nrows), 32'd1);
        if (rp_n < nrows) chk("no_of_multiples", no_of_multiples, 32'(mult_of(nnz_tab[rp_n])));
        rp_n++; dseen = 0; gwait = 1 + int'($urandom_range(0, 3));
      end
      if (I_am_ready) begin
        iar_n++;
        chk("iar_after_accept", 32'(hold || chunk_valid), 32'd0);
        gwait = 1 + int'($urandom_range(0, 3));
      end
      if (hold) chk("valid_held", 32'(chunk_valid), 32'd1);
      if (chunk_valid && hold) begin
        chk("hold_idx", 32'(chunk_idx), 32'(hidx));
        chk("hold_clast", 32'(chunk_last), 32'(hcl));
        chk("hold_rlast", 32'(row_last), 32'(hrl));
      end else if (chunk_valid) begin
        chk("cv_latency", 32'(cyc - ycr_cyc), 32'd2);
        chk("chunk_expected", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("chunk_idx", 32'(chunk_idx), 32'(e.idx));
          chk("chunk_last", 32'(chunk_last), 32'(e.cl));
          chk("row_last", 32'(row_last), 32'(e.rl));
          chk("nom_stable", no_of_multiples, 32'(mult_of(nnz_tab[e.row])));
        end
        hidx = chunk_idx; hcl = chunk_last; hrl = row_last;
        if (abort) begin
          chunk_ready = 1'b0; wr_req = 1'b0; start = 1'b0;
          you_can_read = 1'b0; desc_valid = 1'b0;
          rst_n = 1'b0;
          #1;
          chk_idle("abort");
          step(); chk("abort_no_done", 32'(done), 32'd0);
          step(); rst_n = 1'b1;
          step(); chk_idle("post_abort");
          return;
        end
      end
      case (rmode)
        1: chunk_ready = 1'($urandom_range(0, 1));
        2: if (chunk_valid && rp_n == 1 && chunk_idx == 16'd1 && stall < 5) begin
             chunk_ready = 1'b0; stall++;
           end else chunk_ready = 1'b1;
        default: chunk_ready = 1'b1;
      endcase
      hold = chunk_valid && !chunk_ready;
      if (done) begin
        chk("busy_in_fin", 32'(busy), 32'd1);
        chk("rows_issued", 32'(rp_n), 32'(nrows));
        chk("iar_count", 32'(iar_n), 32'(exp_iar));
        chk("chunks_left", 32'(expq.size()), 32'd0);
        if (rmode == 2) chk("stall_cycles", 32'(stall), 32'd5);
        finished = 1;
      end
      wr_req = randwr && busy && !done && ($urandom_range(0, 2) == 0);
      start  = busy && !done && ($urandom_range(0, 7) == 0);
      step();
    end
    chk("pass_finished", 32'(finished), 32'd1);
    wr_req = 1'b0; start = 1'b0; chunk_ready = 1'b0; you_can_read = 1'b0; desc_valid = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);
    repeat (3) step();
    chk("no_restart", 32'(busy), 32'd0);
  endtask

  initial begin
    // reset state
    step(); step();
    chk_idle("reset");
    rst_n = 1'b1;
    step();
    chk_idle("after_release");

    // basic single row
    nnz_tab = '{8};
    run_pass(1, 32'h100, 0, 0, 0, 0);

    // multi-chunk row then empty row
    nnz_tab = '{20, 0};
    run_pass(2, 32'h200, 0, 0, 0, 0);

    // backpressure on chunk 1 of the first row
    nnz_tab = '{20, 5};
    run_pass(2, 32'h300, 2, 0, 0, 0);

    // write arbitration: start arrives during a 3-cycle write
    nnz_tab = '{3, 9};
    wr_req = 1'b1; start = 1'b1; num_rows = 16'd2; desc_base = 32'h400;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("arb_we", 32'(write_enable), 32'd1);
      chk("arb_busy", 32'(busy), 32'd0);
      if (k == 2) wr_req = 1'b0;
      step();
    end
    chk("arb_accept", 32'(busy), 32'd1);
    run_pass(2, 32'h400, 1, 0, 1, 1);

    // zero rows: straight to done, no descriptor traffic
    nnz_tab.delete();
    run_pass(0, 32'h480, 0, 0, 0, 0);

    // randomized passes with boundary nnz values mixed in
    for (int p = 0; p < 6; p++) begin
      int n;
      n = int'($urandom_range(1, 5));
      nnz_tab.delete();
      for (int r = 0; r < n; r++)
        nnz_tab.push_back(($urandom_range(0, 1) == 1) ? bnd[$urandom_range(0, 7)]
                                                       : int'($urandom_range(0, 40)));
      run_pass(n, 32'h1000 + 32'(p * 64), 1, 0, 1, 0);
    end

    // reset during PRESENT, then a fresh complete pass
    nnz_tab = '{17, 4};
    run_pass(2, 32'h500, 0, 1, 0, 0);
    nnz_tab = '{9, 1, 24};
    run_pass(3, 32'h600, 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
